// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: 2 command bits + DATA_W payload per frame, timed read-back on MISO.
// Define SPI_SLAVE_PARITY_EN to add a trailing even-parity bit and the parity_err port.
module spi_slave_param #(
  parameter int unsigned DATA_W     = 8,
  parameter bit          LSB_FIRST  = 1'b0,
  parameter int unsigned TX_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err
`ifdef SPI_SLAVE_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int unsigned N     = DATA_W + 2;
  localparam int unsigned CNT_W = $clog2(DATA_W + 4);
  localparam int unsigned TO_W  = 8;
`ifdef SPI_SLAVE_PARITY_EN
  localparam int unsigned LAST  = N;
`else
  localparam int unsigned LAST  = N - 1;
`endif

  typedef enum logic [2:0] {IDLE, RX, WAIT_TX, TX, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [N-1:0]      rx_sh;
  logic [DATA_W-1:0] tx_sh;
`ifdef SPI_SLAVE_PARITY_EN
  logic              par;
`endif

  // Bit-order dependent shift paths for receive and transmit
  logic [N-1:0]      rx_shift_c;
  logic [DATA_W-1:0] tx_load_c;
  logic [DATA_W-1:0] tx_adv_c;
  logic              tx_first_c;
  logic              tx_next_c;

  assign rx_shift_c = LSB_FIRST ? ((rx_sh >> 1) | (N'(MOSI) << (N - 1)))
                                : ((rx_sh << 1) | N'(MOSI));
  assign tx_first_c = LSB_FIRST ? tx_data[0] : tx_data[DATA_W-1];
  assign tx_load_c  = LSB_FIRST ? (tx_data >> 1) : (tx_data << 1);
  assign tx_next_c  = LSB_FIRST ? tx_sh[0] : tx_sh[DATA_W-1];
  assign tx_adv_c   = LSB_FIRST ? (tx_sh >> 1) : (tx_sh << 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      to_cnt    <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      MISO      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef SPI_SLAVE_PARITY_EN
      parity_err <= 1'b0;
      par        <= 1'b0;
`endif
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef SPI_SLAVE_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          MISO <= 1'b0;
          if (!SS_n) begin
            rx_sh <= rx_shift_c;
            cnt   <= CNT_W'(1);
            state <= RX;
`ifdef SPI_SLAVE_PARITY_EN
            par   <= MOSI;
`endif
          end
        end
        RX: begin
          if (SS_n) begin
            frame_err <= 1'b1;
            rx_sh     <= '0;
            cnt       <= '0;
            state     <= IDLE;
          end else if (cnt == CNT_W'(LAST)) begin
            cnt    <= '0;
            to_cnt <= '0;
`ifdef SPI_SLAVE_PARITY_EN
            // MOSI carries the parity bit; shift register already holds the frame
            if (par ^ MOSI) begin
              parity_err <= 1'b1;
              state      <= DONE;
            end else begin
              rx_data  <= rx_sh;
              rx_valid <= 1'b1;
              state    <= (rx_sh[N-1:N-2] == 2'b11) ? WAIT_TX : DONE;
            end
`else
            rx_data  <= rx_shift_c;
            rx_valid <= 1'b1;
            state    <= (rx_shift_c[N-1:N-2] == 2'b11) ? WAIT_TX : DONE;
`endif
          end else begin
            rx_sh <= rx_shift_c;
            cnt   <= cnt + CNT_W'(1);
`ifdef SPI_SLAVE_PARITY_EN
            par   <= par ^ MOSI;
`endif
          end
        end
        WAIT_TX: begin
          MISO <= 1'b0;
          if (SS_n) begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end else if (tx_valid) begin
            tx_sh <= tx_load_c;
            MISO  <= tx_first_c;
            cnt   <= '0;
            state <= TX;
          end else if (to_cnt == TO_W'(TX_TIMEOUT)) begin
            frame_err <= 1'b1;
            state     <= DONE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        TX: begin
          if (SS_n) begin
            frame_err <= 1'b1;
            MISO      <= 1'b0;
            tx_sh     <= '0;
            cnt       <= '0;
            state     <= IDLE;
          end else if (cnt == CNT_W'(DATA_W - 1)) begin
            MISO  <= 1'b0;
            cnt   <= '0;
            state <= DONE;
          end else begin
            MISO  <= tx_next_c;
            tx_sh <= tx_adv_c;
            cnt   <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          MISO <= 1'b0;
          if (SS_n) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_param.sv
// Randomised self-checking bench for spi_slave_param: one MSB-first and one LSB-first instance.
`timescale 1ns/1ps
module tb_spi_slave_param;

`ifdef SPI_SLAVE_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       rst, ss_n, mosi, tx_valid, sel;
  logic [7:0] tx_data;
  logic       miso_a, miso_b, rxv_a, rxv_b, ferr_a, ferr_b, perr_a, perr_b;
  logic [9:0] rxd_a, rxd_b;
  int         n_checks = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  spi_slave_param #(.DATA_W(8), .LSB_FIRST(1'b0), .TX_TIMEOUT(15)) u_msb (
    .clk(clk), .rst(rst), .SS_n(ss_n | sel), .MOSI(mosi), .MISO(miso_a),
    .rx_data(rxd_a), .rx_valid(rxv_a), .tx_data(tx_data), .tx_valid(tx_valid & ~sel),
    .frame_err(ferr_a)
`ifdef SPI_SLAVE_PARITY_EN
    , .parity_err(perr_a)
`endif
  );

  spi_slave_param #(.DATA_W(8), .LSB_FIRST(1'b1), .TX_TIMEOUT(5)) u_lsb (
    .clk(clk), .rst(rst), .SS_n(ss_n | ~sel), .MOSI(mosi), .MISO(miso_b),
    .rx_data(rxd_b), .rx_valid(rxv_b), .tx_data(tx_data), .tx_valid(tx_valid & sel),
    .frame_err(ferr_b)
`ifdef SPI_SLAVE_PARITY_EN
    , .parity_err(perr_b)
`endif
  );

`ifndef SPI_SLAVE_PARITY_EN
  assign perr_a = 1'b0;
  assign perr_b = 1'b0;
`endif

  wire       miso = sel ? miso_b : miso_a;
  wire       rxv  = sel ? rxv_b  : rxv_a;
  wire       ferr = sel ? ferr_b : ferr_a;
  wire       perr = sel ? perr_b : perr_a;
  wire [9:0] rxd  = sel ? rxd_b  : rxd_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One frame carrying word w (the value rx_data must show), with optional abort/read/cut.
  task automatic run_frame(input logic [9:0] w, input int abort_at, input int dly,
                           input logic [7:0] txd, input bit bad_par, input int cut_at,
                           input bit cut_rst);
    int   nb;
    int   to;
    bit   lsb;
    logic exp_bit;
    nb  = 10 + PAR;
    lsb = sel;
    to  = sel ? 5 : 15;
    for (int k = 0; k < nb; k++) begin
      if (k > 0) check("rx_quiet", {ferr, rxv, miso}, 3'b000);
      if (k == abort_at) begin
        ss_n = 1'b1; tx_valid = 1'b0;
        tick();
        check("abort_err", {ferr, rxv}, 2'b10);
        tick();
        check("abort_pulse", {ferr, rxv}, 2'b00);
        return;
      end
      ss_n     = 1'b0;
      mosi     = (k < 10) ? (lsb ? w[k] : w[9-k]) : ((^w) ^ bad_par);
      tx_valid = 1'($urandom);
      tx_data  = 8'($urandom);
      tick();
    end
    tx_valid = 1'b0;
    if (bad_par) begin
      check("par_err", {perr, rxv}, 2'b10);
    end else begin
      check("rx_valid", {perr, rxv, ferr}, 3'b010);
      check("rx_data", rxd, w);
      if (w[9:8] == 2'b11) begin
        if (dly < 0) begin
          for (int c = 1; c <= to + 1; c++) begin
            tick();
            check("timeout", {ferr, miso, rxv}, (c == to + 1) ? 3'b100 : 3'b000);
          end
        end else begin
          for (int c = 0; c < dly; c++) begin
            tick();
            check("wait_tx", {ferr, miso, rxv}, 3'b000);
          end
          tx_valid = 1'b1; tx_data = txd;
          tick();
          for (int j = 0; j < 8; j++) begin
            exp_bit = lsb ? txd[j] : txd[7-j];
            check("miso_bit", {ferr, rxv, miso}, {2'b00, exp_bit});
            if (j == cut_at) begin
              tx_valid = 1'b0;
              if (cut_rst) begin
                rst = 1'b1;
                tick();
                check("rst_mid_tx", {miso, rxv, ferr, perr, rxd}, 32'd0);
                rst = 1'b0; ss_n = 1'b1;
                tick();
              end else begin
                ss_n = 1'b1;
                tick();
                check("tx_abort", {ferr, miso}, 2'b10);
                tick();
                check("tx_abort_end", {ferr, miso}, 2'b00);
              end
              return;
            end
            tx_valid = ($urandom % 4 == 0);
            tx_data  = 8'($urandom);
            tick();
          end
          tx_valid = 1'b0;
          check("miso_end", {ferr, miso}, 2'b00);
        end
      end
    end
    for (int c = 0; c < 3; c++) begin
      mosi = 1'($urandom);
      tick();
      check("done_quiet", {perr, ferr, rxv, miso}, 4'b0000);
    end
    ss_n = 1'b1;
    tick();
    check("end_frame", {ferr, miso}, 2'b00);
    tick();
  endtask

  initial begin
    logic [9:0] w;
    int         ab, dl, ct;
    bit         bp;
    rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; sel = 1'b0;
    repeat (3) tick();
    check("reset_a", {miso, rxv, ferr, perr, rxd}, 32'd0);
    sel = 1'b1; #1;
    check("reset_b", {miso, rxv, ferr, perr, rxd}, 32'd0);
    sel = 1'b0; rst = 1'b0;
    tick();

    // MSB-first directed frames
    run_frame(10'h0A5, -1, -1, 8'h00, 1'b0, -1, 1'b0);
    run_frame(10'h300, -1,  1, 8'hC3, 1'b0, -1, 1'b0);
    run_frame(10'h2B7,  5, -1, 8'h00, 1'b0, -1, 1'b0);
    run_frame(10'h1F0, -1, -1, 8'h00, 1'b0, -1, 1'b0);
    run_frame(10'h3C0, -1, -1, 8'h00, 1'b0, -1, 1'b0);
    run_frame(10'h3FF, -1,  0, 8'hA5, 1'b0,  3, 1'b1);
    run_frame(10'h3AA, -1,  2, 8'h5A, 1'b0,  6, 1'b0);
`ifdef SPI_SLAVE_PARITY_EN
    run_frame(10'h0A5, -1, -1, 8'h00, 1'b1, -1, 1'b0);
    run_frame(10'h0A5, -1, -1, 8'h00, 1'b0, -1, 1'b0);
`endif

    // LSB-first directed frames
    sel = 1'b1;
    tick();
    run_frame(10'h1A5, -1, -1, 8'h00, 1'b0, -1, 1'b0);
    run_frame(10'h36C, -1,  0, 8'h01, 1'b0, -1, 1'b0);
    run_frame(10'h3E1, -1, -1, 8'h00, 1'b0, -1, 1'b0);

    // Randomised frames on both instances
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      tick();
      for (int f = 0; f < 40; f++) begin
        w = 10'($urandom);
        if ($urandom % 2 == 0) w[9:8] = 2'b11;
        ab = ($urandom % 6 == 0) ? int'($urandom_range(1, 9 + PAR)) : -1;
        dl = ($urandom % 5 == 0) ? -1 : int'($urandom_range(0, sel ? 4 : 14));
        ct = ($urandom % 6 == 0) ? int'($urandom_range(0, 7)) : -1;
        bp = (PAR != 0) && ($urandom % 4 == 0);
        run_frame(w, ab, dl, 8'($urandom), bp, ct, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_param.md
# spi_slave_param

Parametrised SPI slave, the next generation of the fixed 10-bit slave. It deserialises frames of 2 command bits plus DATA_W payload bits from MOSI and hands each frame to the memory/register interface as a single-cycle rx_valid strobe. For read-data commands it waits a bounded time for tx_valid and serialises tx_data on MISO. It adds frame-abort and timeout error reporting, selectable bit order, and optional parity.

## Interface
- DATA_W, 8: payload width; legal range 4..32; frame length N = DATA_W+2.
- LSB_FIRST, 0: 0 = MSB first on MOSI and MISO, 1 = LSB first.
- TX_TIMEOUT, 15: cycles to wait for tx_valid after a read-data frame, 1..255.
- clk  in  1  single clock; SPI bit clock; all state is sampled on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- SS_n  in  1  slave select, active-low.
- MOSI  in  1  serial data in.
- MISO  out  1  serial data out; 0 when not transmitting.
- rx_data  out  DATA_W+2  {cmd[1:0], payload}; holds its value between frames.
- rx_valid  out  1  one-cycle strobe, rx_data valid.
- tx_data  in  DATA_W  read data from memory.
- tx_valid  in  1  tx_data valid; sampled only in WAIT_TX.
- frame_err  out  1  one-cycle pulse on abort or timeout.
- parity_err  out  1  one-cycle pulse on parity mismatch (present only with SPI_SLAVE_PARITY_EN).

## Operation
- States: IDLE, RX, WAIT_TX, TX, DONE.
- IDLE: on an edge with SS_n=0, sample MOSI as frame bit 0 and go to RX with count=1.
- RX: shift MOSI once per cycle. After the last bit (count reaches N, or N+1 with parity), load rx_data and assert rx_valid. If cmd==2'b11, go to WAIT_TX; otherwise go to DONE.
- Bit order: with LSB_FIRST=0 the first received bit lands in rx_data[N-1]; with LSB_FIRST=1 it lands in rx_data[0].
- Commands 00/01/10 are passed through without interpretation. 11 = read data.
- WAIT_TX: on tx_valid=1, latch tx_data, clear count and go to TX. If TX_TIMEOUT cycles elapse without tx_valid, pulse frame_err and go to DONE.
- TX: drive one latched bit per cycle for DATA_W cycles (MSB-first or LSB-first per LSB_FIRST), then go to DONE.
- DONE: MISO=0 and MOSI is ignored. Return to IDLE when SS_n=1.
- Abort: SS_n=1 in RX, WAIT_TX or TX gives a frame_err pulse, no rx_valid, MISO=0, and return to IDLE. Partial shift contents are discarded.
- tx_valid outside WAIT_TX is ignored. A second tx_valid inside TX is ignored.
- SS_n=1 in DONE is a normal end of frame; no error.

## Timing
- Reset: state=IDLE, count=0, MISO=0, rx_data=0, rx_valid=0, frame_err=0, parity_err=0, shift and tx latches 0.
- Reset takes priority over every event, including mid-RX and mid-TX.
- Frame bit i is sampled at edge i after SS_n is first seen low (i counts from 0).
- rx_valid is high for exactly the cycle after the edge that samples the last bit.
- tx_valid sampled high at edge t: MISO carries data bit 0 in the order cycle after edge t, and the last bit after edge t+DATA_W-1. MISO returns to 0 after edge t+DATA_W.
- Earliest tx_valid is the cycle rx_valid is high, which gives a zero-wait read.
- Timeout: frame_err pulses TX_TIMEOUT+1 cycles after rx_valid if tx_valid is never seen.
- Back-to-back frames require SS_n high for at least one edge between them.
- Counter width: $clog2(DATA_W+4); the counter never wraps within a frame.

## Configuration
- SPI_SLAVE_PARITY_EN defined:
  - RX expects one extra even-parity bit after the N frame bits, so the total number of ones across N+1 bits is even.
  - On a match, rx_valid and the command path behave as above, one cycle later.
  - On a mismatch, parity_err pulses in place of rx_valid, no read is started, and the FSM goes to DONE.
- SPI_SLAVE_PARITY_EN undefined: frames are N bits and the parity_err port and logic are absent.

## Test plan
- Write-address, DATA_W=8, LSB_FIRST=0: send 00_1010_0101 → single rx_valid, rx_data=10'h0A5, MISO stays 0, no frame_err.
- Read-data: send 11_0000_0000, return tx_valid with tx_data=8'hC3 one cycle after rx_valid → MISO = 1,1,0,0,0,0,1,1 on consecutive cycles, then 0.
- Abort: SS_n rises after 5 bits → frame_err pulses once, rx_valid stays 0; the next frame 01_1111_0000 gives rx_data=10'h1F0.
- Timeout and reset: read frame with no tx_valid → frame_err pulses 16 cycles after rx_valid, MISO=0. Repeat and assert rst mid-TX → all outputs 0 next cycle.
- LSB_FIRST=1: send bits 1,0,1,0,0,1,0,1,1,0 → rx_data=10'h1A5. A read with tx_data=8'h01 → MISO 1 then seven 0s.
- With SPI_SLAVE_PARITY_EN: 00_1010_0101 with parity bit 1 → parity_err pulses, no rx_valid. With parity bit 0 → rx_valid, rx_data=10'h0A5.
